rca_settle_sequencer: RTL and testbench
=======================================

// Module: rca_settle_sequencer
// PURPOSE
//  Clocked front/back stage for the combinational sixteenBitAdder ripple-carry adder.
//  - Accepts an operand pair (a, b, cin) over a valid/ready handshake.
//  - Drives the operands, held stable, onto the adder's x/y/cin inputs.
//  - Waits SETTLE_CYCLES clocks for the full carry ripple, then registers s/cout.
//  - Presents the registered result downstream over a second valid/ready handshake.
// PARAMETERS
//  WIDTH          16  operand/sum width; must match the adder instance
//  SETTLE_CYCLES  4   clocks from accept to result capture, >=1; worst-case ripple must settle within it
//  CNT_W          3   settle counter width, >= clog2(SETTLE_CYCLES)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand pair offered
//  in_ready   out  1      sequencer can accept; high only in IDLE
//  in_a       in   WIDTH  operand a
//  in_b       in   WIDTH  operand b
//  in_cin     in   1      carry in
//  add_x      out  WIDTH  to adder x, registered
//  add_y      out  WIDTH  to adder y, registered
//  add_cin    out  1      to adder cin, registered
//  add_s      in   WIDTH  from adder s
//  add_cout   in   1      from adder cout
//  out_valid  out  1      result held
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  captured sum
//  out_cout   out  1      captured carry out
//  txn_count  out  16     completed-result count; wraps FFFF->0000
// BEHAVIOUR
//  Reset values (rst_n low, asynchronous):
//  - state IDLE; counter 0.
//  - add_x/add_y/add_cin 0; out_sum/out_cout/out_valid 0; txn_count 0.
//  - in_ready 1, decoded from IDLE; no handshake takes effect while rst_n is low.
//  FSM:
//  - IDLE: on in_valid&&in_ready, load add_x<=in_a, add_y<=in_b, add_cin<=in_cin; cnt<=SETTLE_CYCLES-1; go SETTLE.
//  - SETTLE: if cnt==0, capture out_sum<=add_s, out_cout<=add_cout, set out_valid<=1, go HOLD; else cnt<=cnt-1.
//  - HOLD: on out_valid&&out_ready, clear out_valid, txn_count<=txn_count+1, go IDLE.
//  Latency:
//  - Accept at edge E; out_valid rises at edge E+SETTLE_CYCLES.
//  - Earliest next accept is edge E+SETTLE_CYCLES+2, i.e. one IDLE bubble.
//  Hold rules:
//  - add_* change only on an accept; they stay stable through SETTLE, HOLD and the following IDLE.
//  - out_sum/out_cout stay stable while out_valid is high, regardless of out_ready.
//  - in_valid outside IDLE is ignored; in_ready is low, so nothing is queued.
//  Arithmetic: none internal; the adder gives {cout,s} = (a+b+cin) mod 2^(WIDTH+1).
//  Reset mid-operation (SETTLE or HOLD): returns to IDLE; the pending result is discarded and not counted.
// CONFIGURATION
//  RCA_OVF_FLAG_EN defined:
//  - Adds output out_ovf (1 bit, reset 0), captured with out_sum in SETTLE.
//  - out_ovf = (add_x[W-1]==add_y[W-1]) && (add_s[W-1]!=add_x[W-1]), i.e. signed two's-complement overflow.
//  - out_ovf is held with out_sum.
//  RCA_OVF_FLAG_EN undefined: port and logic absent; all other behaviour identical.
// TESTING (clk period 10, gate delay #1, SETTLE_CYCLES=4)
//  1. rst_n low 3 cycles -> out_valid=0, out_sum=0, add_x=0, txn_count=0, in_ready=1.
//  2. a=FFFF, b=0001, cin=0, accept at edge 0 -> out_valid at edge 4; out_sum=0000, out_cout=1 (full ripple).
//  3. a=1234, b=4321, cin=1, out_ready low 10 cycles -> out_sum=5556, out_cout=0 held stable;
//     in_ready=0; in_valid pulses ignored; txn_count increments once, on out_ready.
//  4. Accept, then rst_n low at edge 2 of SETTLE -> IDLE; out_valid never rises; txn_count=0.
//  5. 5000 random (a,b,cin), out_ready=1 -> every result matches (a+b+cin) mod 2^17 as {cout,sum}; txn_count=5000.
//  6. [RCA_OVF_FLAG_EN] 7FFF+0001 -> sum 8000, ovf=1; 8000+FFFF -> sum 7FFF, cout=1, ovf=1; 0005+FFFE -> ovf=0.

Source files
------------

// File: rtl/rca_settle_sequencer_if.sv
// Operand/result handshake bundle for rca_settle_sequencer.
// Optional out_ovf is present when RCA_OVF_FLAG_EN is defined.
interface rca_settle_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [15:0]      txn_count;
`ifdef RCA_OVF_FLAG_EN
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin,
    output out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_cout, txn_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    input  out_ready,
    output in_ready, out_valid, out_sum,
    output out_cout, txn_count, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin,
    output out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_cout, txn_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    input  out_ready,
    output in_ready, out_valid, out_sum,
    output out_cout, txn_count
  );
`endif
endinterface

// File: rtl/rca_settle_sequencer.sv
// Clocked wrapper around an external ripple-carry adder.
// Define RCA_OVF_FLAG_EN to add the signed-overflow output out_ovf.
module rca_settle_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  rca_settle_sequencer_if.slave bus,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      add_x         <= '0;
      add_y         <= '0;
      add_cin       <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_cout  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.txn_count <= '0;
`ifdef RCA_OVF_FLAG_EN
      bus.out_ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            add_x   <= bus.in_a;
            add_y   <= bus.in_b;
            add_cin <= bus.in_cin;
            cnt     <= CNT_W'(SETTLE_CYCLES - 1);
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            bus.out_sum   <= add_s;
            bus.out_cout  <= add_cout;
            bus.out_valid <= 1'b1;
`ifdef RCA_OVF_FLAG_EN
            // same-sign operands yielding a different-sign sum
            bus.out_ovf   <=
              (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
              (add_s[WIDTH-1] != add_x[WIDTH-1]);
`endif
            state         <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.txn_count <= bus.txn_count + 16'd1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_settle_sequencer.sv
// Directed and random checks for rca_settle_sequencer.
// The adder is modelled combinationally from add_x/add_y/add_cin.
module tb_rca_settle_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] add_x;
  logic [15:0] add_y;
  logic        add_cin;
  logic [15:0] add_s;
  logic        add_cout;

  int n_chk;
  int n_fail;

  rca_settle_sequencer_if #(.WIDTH(16)) bus ();

  rca_settle_sequencer #(
    .WIDTH(16),
    .SETTLE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .add_x(add_x),
    .add_y(add_y),
    .add_cin(add_cin),
    .add_s(add_s),
    .add_cout(add_cout)
  );

  assign {add_cout, add_s} =
    {1'b0, add_x} + {1'b0, add_y} + {16'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair, accept at next edge, measure latency to out_valid.
  task automatic xfer(input logic [15:0] a,
                      input logic [15:0] b,
                      input logic c,
                      input logic [16:0] exp,
                      input bit detail);
    int lat;
    if (detail) chk("pre_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = c;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (detail || lat != 4) chk("latency", 32'(lat), 32'd4);
    chk("result", 32'({bus.out_cout, bus.out_sum}), 32'(exp));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;

    // 1. reset
    repeat (3) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_add_x", 32'(add_x), 32'd0);
    chk("rst_txn", 32'(bus.txn_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    tick();
    chk("rst_no_accept", 32'(add_x), 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // 2. full ripple
    xfer(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b1);
    chk("t2_in_ready_hold", 32'(bus.in_ready), 32'd0);
    tick();
    chk("t2_consumed", 32'(bus.out_valid), 32'd0);
    chk("t2_txn", 32'(bus.txn_count), 32'd1);
    chk("t2_in_ready", 32'(bus.in_ready), 32'd1);

    // 3. backpressure, ignored in_valid
    bus.out_ready = 1'b0;
    xfer(16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'(i * 16'h0101);
      tick();
      bus.in_valid = 1'b0;
      chk("t3_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_sum", 32'(bus.out_sum), 32'h5556);
      chk("t3_cout", 32'(bus.out_cout), 32'd0);
      chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t3_add_x", 32'(add_x), 32'h1234);
      chk("t3_txn", 32'(bus.txn_count), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t3_consumed", 32'(bus.out_valid), 32'd0);
    chk("t3_txn_done", 32'(bus.txn_count), 32'd2);
    chk("t3_add_x_idle", 32'(add_x), 32'h1234);

    // 4. reset during SETTLE
    bus.in_a     = 16'h0F0F;
    bus.in_b     = 16'h0101;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t4_in_ready_async", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    chk("t4_txn", 32'(bus.txn_count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_no_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("t4_in_ready", 32'(bus.in_ready), 32'd1);

    // 5. random
    for (int i = 0; i < 5000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      xfer(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'd0, rc}, 1'b0);
      tick();
    end
    chk("t5_txn", 32'(bus.txn_count), 32'd5000);

`ifdef RCA_OVF_FLAG_EN
    // 6. overflow flag
    xfer(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
    chk("t6_ovf_a", 32'(bus.out_ovf), 32'd1);
    tick();
    xfer(16'h8000, 16'hFFFF, 1'b0, 17'h17FFF, 1'b1);
    chk("t6_ovf_b", 32'(bus.out_ovf), 32'd1);
    tick();
    xfer(16'h0005, 16'hFFFE, 1'b0, 17'h10003, 1'b1);
    chk("t6_ovf_c", 32'(bus.out_ovf), 32'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
